tinyalu_arbiter: RTL and testbench
==================================

Name: tinyalu_arbiter

Overview:
Shares one TinyALU between NUM_REQ independent requesters. Uses round-robin arbitration, so no requester is starved. Sequences the TinyALU start/done handshake so that op, A and B are held stable from start until done, and start and done are both low in the cycle after done. Returns each 16-bit result to the requester that issued the operation. Sits between the TinyALU datapath and the command sources (testbench drivers or CPU-side logic).

Parameters:
NUM_REQ, 4, number of requesters (2..8).
TIMEOUT_CYCLES, 15, maximum cycles start may stay high without done before the operation is aborted (1..255).

Ports:
clk  input  1  single clock; all state changes on the rising edge.
reset  input  1  asynchronous reset, active-high.
req_valid  input  NUM_REQ  requester i has an operation pending.
req_op  input  3*NUM_REQ  opcode of requester i, in bits [3i+2:3i].
req_a  input  8*NUM_REQ  operand A of requester i.
req_b  input  8*NUM_REQ  operand B of requester i.
req_ready  output  NUM_REQ  one-hot, one-cycle pulse; the operation is accepted when it is high together with req_valid.
rsp_valid  output  NUM_REQ  one-hot, one-cycle pulse marking completion to the owning requester.
rsp_result  output  16  result; valid only while any rsp_valid bit is high.
rsp_err  output  1  qualified by rsp_valid: illegal opcode or timeout.
alu_start  output  1  to TinyALU start.
alu_op  output  3  to TinyALU op.
alu_a  output  8  to TinyALU A.
alu_b  output  8  to TinyALU B.
alu_done  input  1  from TinyALU done.
alu_result  input  16  from TinyALU result.

Behaviour:
- Outputs on reset: all outputs are registered and forced to 0 while reset is high. Last-grant pointer resets to NUM_REQ-1, so requester 0 wins first.
- Opcodes: 001 add, 010 and, 011 xor, 100 mul are forwarded to the ALU. 000 and 101..111 are never forwarded.
- FSM states: IDLE, ISSUE, BUSY, LOCAL, GAP.
- IDLE:
  - If any req_valid is set, pick the winner by round-robin: the first set bit searching upward from last_grant+1, wrapping at NUM_REQ.
  - Pulse req_ready[winner] for exactly one cycle; latch winner, op, A, B; last_grant <= winner.
  - Next state is ISSUE for a legal op, otherwise LOCAL.
  - No request means stay in IDLE with all outputs low.
- ISSUE: drive alu_start=1 with the latched alu_op, alu_a and alu_b; clear the timeout counter; go to BUSY.
- BUSY:
  - alu_start, alu_op, alu_a and alu_b stay constant every cycle.
  - On alu_done=1: capture alu_result, drop alu_start, pulse rsp_valid[winner] with rsp_err=0 in the next cycle, go to GAP.
  - If the counter reaches TIMEOUT_CYCLES with alu_done still 0: drop alu_start, pulse rsp_valid[winner] with rsp_err=1 and rsp_result=0, go to GAP.
  - If alu_done and the timeout fall in the same cycle, done wins.
- GAP:
  - Exactly one cycle.
  - alu_start=0; alu_op, alu_a and alu_b are driven to 0; no new grant is made.
  - Go to IDLE.
  - This guarantees start and done are both low the cycle after done.
- LOCAL:
  - Pulse rsp_valid[winner] with rsp_result=0.
  - rsp_err=0 for op 000; rsp_err=1 for 101..111.
  - alu_start is never asserted.
  - Go to GAP.
- Interval: a new grant can occur at the earliest 1 cycle after GAP. Minimum request-to-request spacing is 4 cycles plus ALU latency.
- Requester rules: a requester must hold req_valid, req_op, req_a and req_b stable until req_ready. Values are sampled only in the grant cycle; later changes do not affect the in-flight operation.
- A requester may re-request while its previous operation is in flight. It is not granted until the FSM returns to IDLE.
- alu_done is ignored in IDLE, LOCAL and GAP. This covers a stray done, including a late done after a timeout; the block never responds to it.
- Reset mid-operation: everything clears immediately and asynchronously. The in-flight operation gets no response.

Test Plan:
- Single add: req 0 with op=001, A=0x12, B=0x34 -> req_ready[0] for 1 cycle; alu_start high until done; rsp_valid[0] with rsp_result=0x0046, rsp_err=0; alu_start=0 in the cycle after done.
- Multiply: req 2 with op=100, A=0xFF, B=0xFF -> alu_op, alu_a and alu_b unchanged across all multi-cycle busy cycles; rsp_result=0xFE01; exactly one rsp_valid[2] pulse.
- Contention: all 4 requesters valid continuously -> grant order 0,1,2,3,0,1; no requester granted twice before the others.
- Local ops:
  - op=000 -> rsp_err=0, rsp_result=0, alu_start never high.
  - op=110 -> rsp_err=1.
- Timeout: ALU model never asserts done -> alu_start drops after 15 busy cycles; rsp_valid with rsp_err=1; a late alu_done pulse afterwards produces no response.
- Reset mid-operation: assert reset while in BUSY -> all outputs 0 immediately; after release, requester 0 wins first.

Source files
------------

// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter: round-robin share of one TinyALU among NUM_REQ requesters.
// req_* in, req_ready/rsp_* out; alu_* is the TinyALU start/done handshake.
module tinyalu_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [3*NUM_REQ-1:0] req_op,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [15:0]          rsp_result,
  output logic                 rsp_err,
  output logic                 alu_start,
  output logic [2:0]           alu_op,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE, ISSUE, BUSY, LOCAL, GAP
  } state_t;

  state_t         state, state_d;
  logic [IW-1:0]  last_grant, winner;
  logic [2:0]     op_q;
  logic [7:0]     a_q, b_q;
  logic [7:0]     cnt;

  logic           gnt_any;
  logic [IW-1:0]  gnt_idx;
  logic [2:0]     gnt_op;
  logic [7:0]     gnt_a, gnt_b;
  logic           gnt_legal;
  logic           timeout;

  logic [NUM_REQ-1:0] ready_d, rsp_valid_d;
  logic [15:0]        result_d;
  logic               err_d, start_d;
  logic [2:0]         op_d;
  logic [7:0]         a_d, b_d;

  // First valid requester searching upward from last_grant+1.
  always_comb begin
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_op  = '0;
    gnt_a   = '0;
    gnt_b   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last_grant) + k) % NUM_REQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(j);
        gnt_op  = req_op[3*j +: 3];
        gnt_a   = req_a[8*j +: 8];
        gnt_b   = req_b[8*j +: 8];
      end
    end
  end

  assign gnt_legal = gnt_op inside {3'b001, 3'b010, 3'b011, 3'b100};
  assign timeout   = (cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      winner     <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      alu_start  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && gnt_any) begin
        winner     <= gnt_idx;
        last_grant <= gnt_idx;
        op_q       <= gnt_op;
        a_q        <= gnt_a;
        b_q        <= gnt_b;
      end
      if (state == ISSUE)
        cnt <= '0;
      else if (state == BUSY)
        cnt <= cnt + 8'd1;
      req_ready  <= ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_result <= result_d;
      rsp_err    <= err_d;
      alu_start  <= start_d;
      alu_op     <= op_d;
      alu_a      <= a_d;
      alu_b      <= b_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (gnt_any)
          state_d = gnt_legal ? ISSUE : LOCAL;
      ISSUE: state_d = BUSY;
      BUSY:
        if (alu_done || timeout)
          state_d = GAP;
      LOCAL: state_d = GAP;
      GAP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered: each value below shows up one cycle later,
  // so a done seen in BUSY yields rsp_valid and start=0 in the GAP cycle.
  always_comb begin
    ready_d     = '0;
    rsp_valid_d = '0;
    result_d    = '0;
    err_d       = 1'b0;
    start_d     = 1'b0;
    op_d        = '0;
    a_d         = '0;
    b_d         = '0;
    unique case (state)
      IDLE:
        if (gnt_any)
          ready_d = NUM_REQ'(1) << gnt_idx;
      ISSUE: begin
        start_d = 1'b1;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
      end
      BUSY:
        if (alu_done) begin
          rsp_valid_d = NUM_REQ'(1) << winner;
          result_d    = alu_result;
        end else if (timeout) begin
          rsp_valid_d = NUM_REQ'(1) << winner;
          err_d       = 1'b1;
        end else begin
          start_d = 1'b1;
          op_d    = op_q;
          a_d     = a_q;
          b_d     = b_q;
        end
      LOCAL: begin
        rsp_valid_d = NUM_REQ'(1) << winner;
        err_d       = (op_q != 3'b000);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb_tinyalu_arbiter: directed checks of tinyalu_arbiter with a
// behavioural TinyALU whose done rises `lat` cycles after start is seen.
module tb_tinyalu_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [3*N-1:0] req_op = '0;
  logic [8*N-1:0] req_a = '0;
  logic [8*N-1:0] req_b = '0;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [15:0]    rsp_result;
  logic           rsp_err, alu_start;
  logic [2:0]     alu_op;
  logic [7:0]     alu_a, alu_b;
  logic           alu_done;
  logic [15:0]    alu_result;

  int   n_checks = 0;
  int   n_fail = 0;

  logic alu_en = 1'b1;
  int   lat = 3;
  int   lcnt;
  logic done_r;
  logic stray_done = 1'b0;
  logic [15:0] model_res;

  always #5 clk = ~clk;

  tinyalu_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_start(alu_start), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      lcnt <= 0;
      done_r <= 1'b0;
      model_res <= '0;
    end else if (alu_en && alu_start && !done_r) begin
      if (lcnt == lat - 1) begin
        done_r <= 1'b1;
        lcnt <= 0;
        case (alu_op)
          3'b001: model_res <= 16'(alu_a) + 16'(alu_b);
          3'b010: model_res <= {8'h00, alu_a & alu_b};
          3'b011: model_res <= {8'h00, alu_a ^ alu_b};
          default: model_res <= 16'(alu_a) * 16'(alu_b);
        endcase
      end else begin
        lcnt <= lcnt + 1;
      end
    end else begin
      done_r <= 1'b0;
      lcnt <= 0;
    end
  end

  assign alu_done   = done_r | stray_done;
  assign alu_result = model_res;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [44:0] all_out();
    return {req_ready, rsp_valid, rsp_result, rsp_err,
            alu_start, alu_op, alu_a, alu_b};
  endfunction

  task automatic wait_ready(output logic [N-1:0] rdy);
    rdy = '0;
    for (int i = 0; i < 80 && rdy == '0; i++) begin
      @(negedge clk);
      rdy = req_ready;
    end
    if (rdy == '0) check("ready_wait", 0, 1);
  endtask

  // Issue one op on requester idx and watch a fixed 40-cycle window.
  task automatic do_op(input int idx, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       output logic [N-1:0] rdy,
                       output logic [N-1:0] rv,
                       output logic [15:0] res,
                       output logic err,
                       output int starts, output int pulses,
                       output bit stable, output bit clean_gap);
    logic prev_done;
    req_op[3*idx +: 3] = op;
    req_a[8*idx +: 8]  = a;
    req_b[8*idx +: 8]  = b;
    req_valid = N'(1) << idx;
    wait_ready(rdy);
    req_valid = '0;
    rv = '0; res = '1; err = 1'bx;
    starts = 0; pulses = 0;
    stable = 1'b1; clean_gap = 1'b1;
    prev_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (alu_start) begin
        starts++;
        if (alu_op != op || alu_a != a || alu_b != b)
          stable = 1'b0;
      end
      if (prev_done && (alu_start || alu_done))
        clean_gap = 1'b0;
      if (rsp_valid != '0) begin
        pulses++;
        rv = rsp_valid; res = rsp_result; err = rsp_err;
        if (alu_start || alu_op != 0 || alu_a != 0 || alu_b != 0)
          clean_gap = 1'b0;
      end
      prev_done = alu_done;
    end
  endtask

  logic [N-1:0] rdy, rv;
  logic [15:0]  res;
  logic         err;
  int           starts, pulses;
  bit           stable, clean_gap;
  int           exp_seq[6] = '{0, 1, 2, 3, 0, 1};
  bit           quiet;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(all_out()), 0);
    reset = 1'b0;
    @(negedge clk);

    // Contention: all four always valid, two-cycle ALU.
    lat = 2;
    req_op = {4{3'b001}};
    req_a = 32'h04030201;
    req_b = 32'h01010101;
    req_valid = 4'hF;
    for (int g = 0; g < 6; g++) begin
      wait_ready(rdy);
      check($sformatf("rr_grant%0d", g), 64'(rdy), 64'(N'(1) << exp_seq[g]));
    end
    req_valid = '0;
    repeat (30) @(negedge clk);

    // Single add, latency 3: start seen L+1 cycles.
    lat = 3;
    do_op(0, 3'b001, 8'h12, 8'h34, rdy, rv, res, err,
          starts, pulses, stable, clean_gap);
    check("add_ready", 64'(rdy), 64'(4'b0001));
    check("add_rsp_valid", 64'(rv), 64'(4'b0001));
    check("add_result", 64'(res), 64'h0046);
    check("add_err", 64'(err), 0);
    check("add_pulses", 64'(pulses), 1);
    check("add_starts", 64'(starts), 4);
    check("add_stable", 64'(stable), 1);
    check("add_gap", 64'(clean_gap), 1);

    // Multiply, latency 4.
    lat = 4;
    do_op(2, 3'b100, 8'hFF, 8'hFF, rdy, rv, res, err,
          starts, pulses, stable, clean_gap);
    check("mul_ready", 64'(rdy), 64'(4'b0100));
    check("mul_rsp_valid", 64'(rv), 64'(4'b0100));
    check("mul_result", 64'(res), 64'hFE01);
    check("mul_pulses", 64'(pulses), 1);
    check("mul_starts", 64'(starts), 5);
    check("mul_stable", 64'(stable), 1);

    // Local ops.
    do_op(1, 3'b000, 8'h55, 8'hAA, rdy, rv, res, err,
          starts, pulses, stable, clean_gap);
    check("nop_rsp_valid", 64'(rv), 64'(4'b0010));
    check("nop_result", 64'(res), 0);
    check("nop_err", 64'(err), 0);
    check("nop_starts", 64'(starts), 0);
    do_op(3, 3'b110, 8'h55, 8'hAA, rdy, rv, res, err,
          starts, pulses, stable, clean_gap);
    check("ill_rsp_valid", 64'(rv), 64'(4'b1000));
    check("ill_err", 64'(err), 1);
    check("ill_result", 64'(res), 0);
    check("ill_starts", 64'(starts), 0);

    // Timeout: the ALU never answers.
    alu_en = 1'b0;
    do_op(0, 3'b011, 8'h0F, 8'hF0, rdy, rv, res, err,
          starts, pulses, stable, clean_gap);
    check("to_starts", 64'(starts), 15);
    check("to_rsp_valid", 64'(rv), 64'(4'b0001));
    check("to_err", 64'(err), 1);
    check("to_result", 64'(res), 0);
    check("to_pulses", 64'(pulses), 1);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid != '0 || req_ready != '0 || alu_start) quiet = 1'b0;
    end
    check("late_done_ignored", 64'(quiet), 1);

    // Reset while BUSY.
    req_op[3*2 +: 3] = 3'b001;
    req_valid = 4'b0100;
    wait_ready(rdy);
    req_valid = '0;
    for (int i = 0; i < 10 && !alu_start; i++) @(negedge clk);
    @(negedge clk);
    check("busy_before_reset", 64'(alu_start), 1);
    reset = 1'b1;
    #1;
    check("reset_mid_outputs", 64'(all_out()), 0);
    @(negedge clk);
    reset = 1'b0;
    alu_en = 1'b1;
    req_valid = 4'hF;
    wait_ready(rdy);
    check("post_reset_first", 64'(rdy), 64'(4'b0001));
    req_valid = '0;
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
